// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// rf_wb_arbiter : register-file write-port owner; merges fixed-priority WB
//                 writes with a FIFO of multicycle completions.
// Optional      : RF_WB_TRACE_EN enables a per-commit simulation trace.
// Revision      : 1.0  initial release
// ============================================================================
module rf_wb_arbiter #(
  parameter int QDEPTH     = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      p_we,
  input  logic [4:0]                p_rd,
  input  logic [31:0]               p_wd,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [4:0]                s_rd,
  input  logic [31:0]               s_wd,
  output logic                      rf_we,
  output logic [4:0]                rf_waddr,
  output logic [31:0]               rf_wdata,
  input  logic [4:0]                q_a1,
  input  logic [4:0]                q_a2,
  output logic                      q_hit1,
  output logic                      q_hit2,
  output logic                      wb_stall,
  output logic [$clog2(QDEPTH):0]   q_count
);

  localparam int              AW     = $clog2(QDEPTH);
  localparam int              CW     = AW + 1;
  localparam logic [CW-1:0]   C_FULL = CW'(QDEPTH);
  localparam logic [7:0]      C_SMAX = 8'(STARVE_MAX);

  logic [4:0]        rd_mem_q [QDEPTH];
  logic [31:0]       wd_mem_q [QDEPTH];
  logic [QDEPTH-1:0] vld_q, vld_d;
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [7:0]        starve_q, starve_d;
  logic              rf_we_q, rf_we_d;
  logic [4:0]        rf_waddr_q, rf_waddr_d;
  logic [31:0]       rf_wdata_q, rf_wdata_d;

  logic              p_valid;
  logic              q_empty;
  logic              accept;
  logic              push;
  logic              pop;
  logic [QDEPTH-1:0] hit1_vec;
  logic [QDEPTH-1:0] hit2_vec;

  // s_ready is a pure function of the registered occupancy, so the producer
  // never sees a combinational path from p_we.
  assign s_ready = (cnt_q != C_FULL);

  always_comb begin
    p_valid    = p_we && (p_rd != 5'd0);
    q_empty    = (cnt_q == '0);
    accept     = s_valid && s_ready;
    push       = accept && (s_rd != 5'd0);
    pop        = !p_valid && !q_empty;

    vld_d      = vld_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    cnt_d      = cnt_q + CW'(push) - CW'(pop);
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    starve_d   = starve_q;

    if (push) begin
      vld_d[wptr_q] = 1'b1;
      wptr_d        = wptr_q + 1'b1;
    end
    if (pop) begin
      vld_d[rptr_q] = 1'b0;
      rptr_d        = rptr_q + 1'b1;
    end

    if (p_valid) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = p_rd;
      rf_wdata_d = p_wd;
    end else if (pop) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = rd_mem_q[rptr_q];
      rf_wdata_d = wd_mem_q[rptr_q];
    end

    // A non-empty queue without a pop means the primary won this cycle.
    if (pop || q_empty) begin
      starve_d = 8'd0;
    end else if (starve_q != C_SMAX) begin
      starve_d = starve_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      starve_q   <= 8'd0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= 5'd0;
      rf_wdata_q <= 32'd0;
    end else begin
      vld_q      <= vld_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      starve_q   <= starve_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  // Payload storage needs no reset; validity is tracked in vld_q.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem_q[wptr_q] <= s_rd;
      wd_mem_q[wptr_q] <= s_wd;
    end
  end

  for (genvar i = 0; i < QDEPTH; i++) begin : g_hit
    assign hit1_vec[i] = vld_q[i] && (rd_mem_q[i] == q_a1);
    assign hit2_vec[i] = vld_q[i] && (rd_mem_q[i] == q_a2);
  end

  assign q_hit1   = (q_a1 != 5'd0) && (|hit1_vec);
  assign q_hit2   = (q_a2 != 5'd0) && (|hit2_vec);
  assign wb_stall = (starve_q == C_SMAX) || (cnt_q == C_FULL);
  assign q_count  = cnt_q;
  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

`ifdef RF_WB_TRACE_EN
  logic src_q, src_d;

  always_comb begin
    src_d = src_q;
    if (p_valid) begin
      src_d = 1'b0;
    end else if (pop) begin
      src_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q <= 1'b0;
    end else begin
      src_q <= src_d;
    end
  end

  always @(posedge clk) begin
    if (rst_n && rf_we_q) begin
      if (src_q) begin
        $display("wb[S] r[%2d] = 0x%8X", rf_waddr_q, rf_wdata_q);
      end else begin
        $display("wb[P] r[%2d] = 0x%8X", rf_waddr_q, rf_wdata_q);
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// tb_rf_wb_arbiter : directed bench with a queue-level reference model.
// Revision         : 1.0  initial release
// ============================================================================
module tb_rf_wb_arbiter;

  localparam int QDEPTH = 4;
  localparam int SMAX   = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p_we = 1'b0;
  logic [4:0]  p_rd = 5'd0;
  logic [31:0] p_wd = 32'd0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [4:0]  s_rd = 5'd0;
  logic [31:0] s_wd = 32'd0;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  q_a1 = 5'd0;
  logic [4:0]  q_a2 = 5'd0;
  logic        q_hit1, q_hit2, wb_stall;
  logic [2:0]  q_count;

  int n_chk  = 0;
  int n_fail = 0;

  rf_wb_arbiter #(.QDEPTH(QDEPTH), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .p_we(p_we), .p_rd(p_rd), .p_wd(p_wd),
    .s_valid(s_valid), .s_ready(s_ready), .s_rd(s_rd), .s_wd(s_wd),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .q_a1(q_a1), .q_a2(q_a2), .q_hit1(q_hit1), .q_hit2(q_hit2),
    .wb_stall(wb_stall), .q_count(q_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model: a plain queue of pending writes ------
  typedef struct packed { logic [4:0] rd; logic [31:0] wd; } ent_t;
  ent_t        mq[$];
  ent_t        m_e;
  logic        m_we = 1'b0;
  logic [4:0]  m_addr = 5'd0;
  logic [31:0] m_data = 32'd0;
  int          m_starve = 0;
  bit          m_pv, m_ne, m_acc, m_h1, m_h2;

  always @(posedge clk) begin
    if (rst_n === 1'b1) begin
      m_pv  = p_we && (p_rd != 5'd0);
      m_ne  = (mq.size() != 0);
      m_acc = s_valid && (mq.size() < QDEPTH);
      if (m_pv) begin
        m_we = 1'b1; m_addr = p_rd; m_data = p_wd;
        m_starve = m_ne ? ((m_starve < SMAX) ? m_starve + 1 : m_starve) : 0;
      end else if (m_ne) begin
        m_e = mq.pop_front();
        m_we = 1'b1; m_addr = m_e.rd; m_data = m_e.wd;
        m_starve = 0;
      end else begin
        m_we = 1'b0;
        m_starve = 0;
      end
      if (m_acc && (s_rd != 5'd0)) mq.push_back('{rd: s_rd, wd: s_wd});
    end
  end

  always @(negedge rst_n) begin
    mq.delete();
    m_we = 1'b0; m_addr = 5'd0; m_data = 32'd0; m_starve = 0;
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      m_h1 = 1'b0; m_h2 = 1'b0;
      foreach (mq[k]) begin
        if (q_a1 != 5'd0 && mq[k].rd == q_a1) m_h1 = 1'b1;
        if (q_a2 != 5'd0 && mq[k].rd == q_a2) m_h2 = 1'b1;
      end
      chk("m_rf_we",    32'(rf_we),    32'(m_we));
      chk("m_rf_waddr", 32'(rf_waddr), 32'(m_addr));
      chk("m_rf_wdata", rf_wdata,      m_data);
      chk("m_q_count",  32'(q_count),  32'(mq.size()));
      chk("m_s_ready",  32'(s_ready),  32'(mq.size() != QDEPTH));
      chk("m_wb_stall", 32'(wb_stall), 32'(m_starve == SMAX || mq.size() == QDEPTH));
      chk("m_q_hit1",   32'(q_hit1),   32'(m_h1));
      chk("m_q_hit2",   32'(q_hit2),   32'(m_h2));
    end
  end

  // ---------------- directed stimulus -------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    #12;
    chk("rst_rf_we",    32'(rf_we), 0);
    chk("rst_waddr",    32'(rf_waddr), 0);
    chk("rst_wdata",    rf_wdata, 0);
    chk("rst_q_count",  32'(q_count), 0);
    chk("rst_s_ready",  32'(s_ready), 1);
    chk("rst_wb_stall", 32'(wb_stall), 0);
    rst_n = 1'b1;
    tick();

    // primary write, one-cycle latency and single pulse
    p_we = 1'b1; p_rd = 5'd5; p_wd = 32'h1234_5678;
    tick();
    p_we = 1'b0;
    chk("p_we",    32'(rf_we), 1);
    chk("p_waddr", 32'(rf_waddr), 5);
    chk("p_wdata", rf_wdata, 32'h1234_5678);
    tick();
    chk("p_pulse", 32'(rf_we), 0);

    // secondary write, two cycles accept to commit, visible to hazard query
    q_a1 = 5'd7; q_a2 = 5'd9;
    s_valid = 1'b1; s_rd = 5'd7; s_wd = 32'hDEAD_BEEF;
    tick();
    s_valid = 1'b0;
    chk("s_hit1",  32'(q_hit1), 1);
    chk("s_cnt1",  32'(q_count), 1);
    chk("s_nowe",  32'(rf_we), 0);
    tick();
    chk("s_we",    32'(rf_we), 1);
    chk("s_waddr", 32'(rf_waddr), 7);
    chk("s_wdata", rf_wdata, 32'hDEAD_BEEF);
    chk("s_cnt0",  32'(q_count), 0);
    chk("s_hit0",  32'(q_hit1), 0);
    tick();

    // fill the queue under continuous primary traffic
    q_a1 = 5'd12;
    for (int i = 0; i < 4; i++) begin
      p_we = 1'b1; p_rd = 5'(1 + i); p_wd = 32'(100 + i);
      s_valid = 1'b1; s_rd = 5'(10 + i); s_wd = 32'(32'hA000 + i);
      tick();
    end
    chk("f_ready", 32'(s_ready), 0);
    chk("f_stall", 32'(wb_stall), 1);
    chk("f_cnt",   32'(q_count), 4);
    chk("f_hit",   32'(q_hit1), 1);
    p_we = 1'b0; s_rd = 5'd14; s_wd = 32'hBAD0;  // offered while full: refused
    tick();
    s_valid = 1'b0;
    chk("f_pop",    32'(rf_waddr), 10);
    chk("f_ready1", 32'(s_ready), 1);
    chk("f_cnt3",   32'(q_count), 3);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("f_drain", 32'(rf_waddr), 32'(11 + i));
    end
    tick();
    chk("f_empty", 32'(rf_we), 0);
    chk("f_cnt0",  32'(q_count), 0);

    // starvation: one queued entry, primary wins every cycle
    s_valid = 1'b1; s_rd = 5'd20; s_wd = 32'h2020;
    tick();
    s_valid = 1'b0;
    p_we = 1'b1; p_rd = 5'd3; p_wd = 32'h33;
    for (int i = 0; i < 7; i++) tick();
    chk("st_7", 32'(wb_stall), 0);
    tick();
    chk("st_8", 32'(wb_stall), 1);
    tick();
    chk("st_sat", 32'(wb_stall), 1);
    p_we = 1'b0;
    tick();
    chk("st_pop",   32'(rf_waddr), 20);
    chk("st_clr",   32'(wb_stall), 0);
    chk("st_cnt",   32'(q_count), 0);

    // writes to x0 are dropped on both sides
    p_we = 1'b1; p_rd = 5'd0; p_wd = 32'hFFFF;
    s_valid = 1'b1; s_rd = 5'd0; s_wd = 32'hEEEE;
    tick();
    p_we = 1'b0; s_valid = 1'b0;
    chk("x0_we",    32'(rf_we), 0);
    chk("x0_cnt",   32'(q_count), 0);
    chk("x0_ready", 32'(s_ready), 1);

    // asynchronous reset with three queued entries
    q_a1 = 5'd21;
    for (int i = 0; i < 3; i++) begin
      p_we = 1'b1; p_rd = 5'(1 + i); p_wd = 32'(i);
      s_valid = 1'b1; s_rd = 5'(21 + i); s_wd = 32'(32'hC000 + i);
      tick();
    end
    s_valid = 1'b0;
    chk("ar_pre", 32'(q_count), 3);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_cnt",   32'(q_count), 0);
    chk("ar_we",    32'(rf_we), 0);
    chk("ar_ready", 32'(s_ready), 1);
    chk("ar_addr",  32'(rf_waddr), 0);
    chk("ar_hit",   32'(q_hit1), 0);
    #2 rst_n = 1'b1;
    p_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("ar_nowr", 32'(rf_we), 0);
    end

    // mixed traffic checked by the model
    for (int i = 0; i < 40; i++) begin
      p_we = (i % 3 != 0); p_rd = 5'(i % 7); p_wd = 32'(i * 32'h0101);
      s_valid = (i % 2 == 0) || (i % 5 == 1);
      s_rd = 5'((i * 3) % 32); s_wd = 32'(32'h5000 + i);
      q_a1 = 5'((i * 3) % 32); q_a2 = 5'((i * 3 + 29) % 32);
      tick();
    end
    p_we = 1'b0; s_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
